fft_reorder_buf: RTL and testbench

Downstream neighbour of the CBFP normalisation stage. Accepts 16-lane, 13-bit complex CBFP output beats, which arrive in bit-reversed frame order, and streams each frame out in natural frequency order. Uses a ping-pong pair of frame banks so that one frame can be written while the previous frame is read. Provides frame-boundary flags for downstream packing.

---
 rtl/fft_reorder_buf.sv | 147 ++++++++++++++
 tb/tb_fft_reorder_buf.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/fft_reorder_buf.sv
//==============================================================================
// fft_reorder_buf : ping-pong frame buffer, bit-reversed in -> natural order out
// Rev 1.0
//==============================================================================
`default_nettype none

module fft_reorder_buf #(
  parameter int W     = 13,
  parameter int LANES = 16,
  parameter int N     = 512
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                valid_in,
  input  logic signed [W-1:0] data_re_in  [0:LANES-1],
  input  logic signed [W-1:0] data_im_in  [0:LANES-1],
  output logic signed [W-1:0] data_re_out [0:LANES-1],
  output logic signed [W-1:0] data_im_out [0:LANES-1],
  output logic                valid_out,
  output logic                sof_out,
  output logic                eof_out
);

  localparam int BEATS = N / LANES;
  localparam int AW    = $clog2(N);
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  // Both banks live in one array; the top index bit selects the bank.
  logic signed [W-1:0] mem_re [0:2*N-1];
  logic signed [W-1:0] mem_im [0:2*N-1];

  state_t              r_state;
  logic                r_wr_bank;
  logic                r_rd_bank;
  logic [BW-1:0]       r_wr_beat;
  logic [BW-1:0]       r_rd_beat;
  logic [1:0]          r_full;
  logic                r_valid_out;
  logic                r_sof;
  logic                r_eof;
  logic signed [W-1:0] r_re [0:LANES-1];
  logic signed [W-1:0] r_im [0:LANES-1];

  logic                w_active;
  logic [BW-1:0]       w_beat;
  logic                w_last_rd;
  logic                w_last_wr;
  logic [1:0]          w_set;
  logic [1:0]          w_clr;

  function automatic logic [AW-1:0] bitrev(input logic [AW-1:0] a);
    logic [AW-1:0] r;
    for (int i = 0; i < AW; i++) begin
      r[i] = a[AW-1-i];
    end
    return r;
  endfunction

  function automatic logic [AW-1:0] lin_addr(input logic [BW-1:0] beat, input int lane);
    return AW'(beat) * AW'(LANES) + AW'(lane);
  endfunction

  // Beat 0 is read in the same cycle the FSM notices a full bank, so the
  // first output lands one edge after the frame's last write.
  always_comb begin
    w_active  = (r_state == STREAM) || r_full[r_rd_bank];
    w_beat    = (r_state == STREAM) ? r_rd_beat : '0;
    w_last_rd = w_active && (w_beat == BW'(BEATS-1));
    w_last_wr = valid_in && (r_wr_beat == BW'(BEATS-1));
    w_set     = w_last_wr ? (2'b01 << r_wr_bank) : 2'b00;
    w_clr     = w_last_rd ? (2'b01 << r_rd_bank) : 2'b00;
  end

  always_ff @(posedge clk) begin
    if (!rstn && valid_in) begin
      for (int l = 0; l < LANES; l++) begin
        mem_re[{r_wr_bank, bitrev(lin_addr(r_wr_beat, l))}] <= data_re_in[l];
        mem_im[{r_wr_bank, bitrev(lin_addr(r_wr_beat, l))}] <= data_im_in[l];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      r_state     <= IDLE;
      r_wr_bank   <= 1'b0;
      r_rd_bank   <= 1'b0;
      r_wr_beat   <= '0;
      r_rd_beat   <= '0;
      r_full      <= 2'b00;
      r_valid_out <= 1'b0;
      r_sof       <= 1'b0;
      r_eof       <= 1'b0;
      for (int l = 0; l < LANES; l++) begin
        r_re[l] <= '0;
        r_im[l] <= '0;
      end
    end else begin
      r_full <= (r_full & ~w_clr) | w_set;

      if (valid_in) begin
        r_wr_beat <= w_last_wr ? '0 : r_wr_beat + BW'(1);
        if (w_last_wr) begin
          r_wr_bank <= ~r_wr_bank;
        end
      end

      r_valid_out <= w_active;
      r_sof       <= w_active && (w_beat == '0);
      r_eof       <= w_last_rd;

      if (w_active) begin
        for (int l = 0; l < LANES; l++) begin
          r_re[l] <= mem_re[{r_rd_bank, lin_addr(w_beat, l)}];
          r_im[l] <= mem_im[{r_rd_bank, lin_addr(w_beat, l)}];
        end
        if (w_last_rd) begin
          r_rd_bank <= ~r_rd_bank;
          r_rd_beat <= '0;
          r_state   <= (r_full[~r_rd_bank] || w_set[~r_rd_bank]) ? STREAM : IDLE;
        end else begin
          r_rd_beat <= w_beat + BW'(1);
          r_state   <= STREAM;
        end
      end
    end
  end

  generate
    for (genvar l = 0; l < LANES; l++) begin : g_lane_out
      assign data_re_out[l] = r_re[l];
      assign data_im_out[l] = r_im[l];
    end
  endgenerate

  assign valid_out = r_valid_out;
  assign sof_out   = r_sof;
  assign eof_out   = r_eof;

endmodule

`default_nettype wire

// File: tb/tb_fft_reorder_buf.sv
//==============================================================================
// tb_fft_reorder_buf : randomized frame-level scoreboard for fft_reorder_buf
// Rev 1.0
//==============================================================================
`default_nettype none

module tb_fft_reorder_buf;

  localparam int W     = 13;
  localparam int LANES = 16;
  localparam int N     = 512;
  localparam int BEATS = N / LANES;
  localparam int AW    = 9;

  logic                clk = 1'b0;
  logic                rstn;
  logic                valid_in;
  logic signed [W-1:0] data_re_in  [0:LANES-1];
  logic signed [W-1:0] data_im_in  [0:LANES-1];
  logic signed [W-1:0] data_re_out [0:LANES-1];
  logic signed [W-1:0] data_im_out [0:LANES-1];
  logic                valid_out;
  logic                sof_out;
  logic                eof_out;

  fft_reorder_buf #(.W(W), .LANES(LANES), .N(N)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .valid_in    (valid_in),
    .data_re_in  (data_re_in),
    .data_im_in  (data_im_in),
    .data_re_out (data_re_out),
    .data_im_out (data_im_out),
    .valid_out   (valid_out),
    .sof_out     (sof_out),
    .eof_out     (eof_out)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int in_beat     = 0;
  int frames_in   = 0;
  int last_m      = -1;

  // Frame under construction, indexed by arrival index k.
  logic [W-1:0] frm_re [N];
  logic [W-1:0] frm_im [N];
  // Expected output samples in emission order, plus each frame's first output cycle.
  logic [W-1:0] exp_re [$];
  logic [W-1:0] exp_im [$];
  int           fstart [$];

  function automatic int bitrev(input int k);
    int r = 0;
    for (int i = 0; i < AW; i++) begin
      if (((k >> i) & 1) == 1) r = r | (1 << (AW - 1 - i));
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic tick();
    bit           was_rst;
    bit           cap;
    int           m;
    logic [W-1:0] g;
    logic [W-1:0] e;
    was_rst = rstn;
    cap     = valid_in && !rstn;
    @(posedge clk);
    cyc++;
    if (was_rst) begin
      in_beat = 0;
      exp_re.delete();
      exp_im.delete();
      fstart.delete();
    end else if (cap) begin
      for (int l = 0; l < LANES; l++) begin
        frm_re[in_beat*LANES + l] = data_re_in[l];
        frm_im[in_beat*LANES + l] = data_im_in[l];
      end
      in_beat++;
      if (in_beat == BEATS) begin
        // Natural-order address a holds the sample that arrived as index bitrev(a).
        for (int a = 0; a < N; a++) begin
          exp_re.push_back(frm_re[bitrev(a)]);
          exp_im.push_back(frm_im[bitrev(a)]);
        end
        fstart.push_back(cyc + 1);
        in_beat = 0;
        frames_in++;
      end
    end
    #1;
    last_m = -1;
    if (was_rst) begin
      check("rst valid", 32'(valid_out), 32'd0);
      check("rst sof",   32'(sof_out),   32'd0);
      check("rst eof",   32'(eof_out),   32'd0);
      for (int l = 0; l < LANES; l++) begin
        g = data_re_out[l];
        check($sformatf("rst re[%0d]", l), 32'(g), 32'd0);
        g = data_im_out[l];
        check($sformatf("rst im[%0d]", l), 32'(g), 32'd0);
      end
    end else if (fstart.size() > 0 && fstart[0] <= cyc) begin
      m = cyc - fstart[0];
      last_m = m;
      check("valid", 32'(valid_out), 32'd1);
      check("sof",   32'(sof_out),   32'(m == 0));
      check("eof",   32'(eof_out),   32'(m == BEATS - 1));
      for (int l = 0; l < LANES; l++) begin
        g = data_re_out[l];
        e = exp_re[m*LANES + l];
        check($sformatf("re beat%0d lane%0d", m, l), 32'(g), 32'(e));
        g = data_im_out[l];
        e = exp_im[m*LANES + l];
        check($sformatf("im beat%0d lane%0d", m, l), 32'(g), 32'(e));
      end
      if (m == BEATS - 1) begin
        for (int a = 0; a < N; a++) begin
          void'(exp_re.pop_front());
          void'(exp_im.pop_front());
        end
        void'(fstart.pop_front());
      end
    end else begin
      check("idle valid", 32'(valid_out), 32'd0);
      check("idle sof",   32'(sof_out),   32'd0);
      check("idle eof",   32'(eof_out),   32'd0);
    end
  endtask

  // ramp=1: re = off+k, im = -(off+k); ramp=0: random samples.
  task automatic drive(input int off, input bit ramp);
    int k;
    for (int l = 0; l < LANES; l++) begin
      k = in_beat*LANES + l;
      if (ramp) begin
        data_re_in[l] = W'(off + k);
        data_im_in[l] = W'(-(off + k));
      end else begin
        data_re_in[l] = W'($urandom);
        data_im_in[l] = W'($urandom);
      end
    end
    valid_in = 1'b1;
    tick();
    valid_in = 1'b0;
  endtask

  task automatic idle(input int n);
    valid_in = 1'b0;
    repeat (n) tick();
  endtask

  task automatic do_reset();
    valid_in = 1'b0;
    rstn     = 1'b1;
    tick();
    rstn     = 1'b0;
  endtask

  initial begin
    int guard;
    rstn     = 1'b1;
    valid_in = 1'b0;
    for (int l = 0; l < LANES; l++) begin
      data_re_in[l] = '0;
      data_im_in[l] = '0;
    end
    repeat (3) tick();
    rstn = 1'b0;
    idle(2);

    // Single ramp frame.
    for (int b = 0; b < BEATS; b++) drive(0, 1'b1);
    idle(40);

    // Three back-to-back frames, distinct offsets.
    for (int f = 0; f < 3; f++) begin
      for (int b = 0; b < BEATS; b++) drive(f*1000, 1'b1);
    end
    idle(40);

    // Gapped random input at ~50% duty.
    frames_in = 0;
    guard     = 0;
    while (frames_in < 3 && guard < 1000) begin
      if ($urandom_range(1, 0) == 1) drive(0, 1'b0);
      else idle(1);
      guard++;
    end
    check("gapped frames done", 32'(frames_in), 32'd3);
    idle(40);

    // Reset after input beat 10, then a clean frame.
    for (int b = 0; b <= 10; b++) drive(0, 1'b0);
    do_reset();
    for (int b = 0; b < BEATS; b++) drive(3000, 1'b1);
    idle(40);

    // Reset while output beat 15 is on the bus.
    for (int b = 0; b < BEATS; b++) drive(0, 1'b0);
    guard = 0;
    while (last_m != 15 && guard < 100) begin
      idle(1);
      guard++;
    end
    check("reached out beat 15", 32'(last_m), 32'd15);
    do_reset();
    idle(40);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
